// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID-stage hazard controller.
//   fwd_sel_e  : operand source select (RF / EXE / MEM / WB)
//   hz_entry_t : shadow record of one in-flight instruction's destination
//   STG_*      : bit positions of each stage in the hit vectors
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic       v;     // entry holds a live instruction
    logic       we;    // instruction writes the register file
    logic [4:0] dest;  // destination register
    logic       ld;    // instruction is a load (data not ready in EXE)
  } hz_entry_t;

  localparam int STG_EXE = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;
  localparam int NUM_STG = 3;

endpackage

// File: rtl/hz_src_match.sv
// Combinational RAW match of one ID source register against the three
// tracker entries.
// Ports:
//   i_raddr/i_ren        : source register and its read enable
//   i_exe/i_mem/i_wb     : tracker entries
//   o_hit[NUM_STG-1:0]   : per-stage hit, indexed by STG_*
//   o_sel                : youngest hitting stage, FWD_RF when none
module hz_src_match
  import pipe_pkg::*;
(
  input  logic [4:0]         i_raddr,
  input  logic               i_ren,
  input  hz_entry_t          i_exe,
  input  hz_entry_t          i_mem,
  input  hz_entry_t          i_wb,
  output logic [NUM_STG-1:0] o_hit,
  output fwd_sel_e           o_sel
);

  // r0 is hard-wired zero, so a write to it never creates a dependency.
  function automatic logic hit_f(hz_entry_t e, logic [4:0] a, logic ren);
    return e.v & e.we & (e.dest != 5'd0) & ren & (a == e.dest);
  endfunction

  always_comb begin
    o_hit          = '0;
    o_hit[STG_EXE] = hit_f(i_exe, i_raddr, i_ren);
    o_hit[STG_MEM] = hit_f(i_mem, i_raddr, i_ren);
    o_hit[STG_WB]  = hit_f(i_wb,  i_raddr, i_ren);

    // Youngest producer holds the architecturally newest value.
    o_sel = FWD_RF;
    if (o_hit[STG_EXE])      o_sel = FWD_EXE;
    else if (o_hit[STG_MEM]) o_sel = FWD_MEM;
    else if (o_hit[STG_WB])  o_sel = FWD_WB;
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard/interlock controller for a 5-stage pipeline.
// Tracks destination registers of instructions in EXE/MEM/WB and derives
// the ID stall and per-operand forwarding selects combinationally.
// Ports:
//   clk, resetn                       : clock, async active-low reset
//   id_valid, id_raddr1/2, id_ren1/2  : ID instruction and its sources
//   id_rf_we, id_waddr, id_is_load    : ID instruction's destination info
//   exe/mem/wb_allowin                : downstream stage acceptance
//   id_blocking                       : ID must not issue this cycle
//   fwd_sel1, fwd_sel2                : operand sources (fwd_sel_e)
//   stall_cnt                         : saturating count of stall cycles
//
// Handshake: a stage transfer happens in a cycle where the sender holds a
// valid instruction and the receiver's allowin is 1; ID transfers when
// id_valid & ~id_blocking & exe_allowin. The tracker advances on exactly
// those transfers so it always mirrors the real pipeline occupancy.
module id_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FORWARD_EN = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic [4:0]       id_raddr1,
  input  logic [4:0]       id_raddr2,
  input  logic             id_ren1,
  input  logic             id_ren2,
  input  logic             id_rf_we,
  input  logic [4:0]       id_waddr,
  input  logic             id_is_load,
  input  logic             exe_allowin,
  input  logic             mem_allowin,
  input  logic             wb_allowin,
  output logic             id_blocking,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt
);

  hz_entry_t          r_exe, r_mem, r_wb;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [NUM_STG-1:0] w_hit1, w_hit2;
  fwd_sel_e           w_sel1, w_sel2;
  logic               w_load_use, w_any_hit, w_stall, w_id_fire;
  logic               w_exe_to_mem, w_mem_to_wb;

  hz_src_match u_match1 (
    .i_raddr (id_raddr1),
    .i_ren   (id_ren1),
    .i_exe   (r_exe),
    .i_mem   (r_mem),
    .i_wb    (r_wb),
    .o_hit   (w_hit1),
    .o_sel   (w_sel1)
  );

  hz_src_match u_match2 (
    .i_raddr (id_raddr2),
    .i_ren   (id_ren2),
    .i_exe   (r_exe),
    .i_mem   (r_mem),
    .i_wb    (r_wb),
    .o_hit   (w_hit2),
    .o_sel   (w_sel2)
  );

  // With forwarding only a load still in EXE is unresolvable; a load in MEM
  // has its data available for the MEM bypass.
  assign w_load_use = (w_hit1[STG_EXE] | w_hit2[STG_EXE]) & r_exe.ld;
  assign w_any_hit  = (|w_hit1) | (|w_hit2);
  assign w_stall    = (FORWARD_EN != 0) ? w_load_use : w_any_hit;

  assign id_blocking = id_valid & w_stall;
  assign fwd_sel1    = (id_valid && FORWARD_EN != 0) ? w_sel1 : FWD_RF;
  assign fwd_sel2    = (id_valid && FORWARD_EN != 0) ? w_sel2 : FWD_RF;
  assign stall_cnt   = r_stall_cnt;

  assign w_id_fire    = id_valid & ~id_blocking & exe_allowin;
  assign w_exe_to_mem = mem_allowin & r_exe.v;
  assign w_mem_to_wb  = wb_allowin & r_mem.v;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_exe <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      if (w_id_fire) begin
        r_exe <= '{v: 1'b1, we: id_rf_we, dest: id_waddr, ld: id_is_load};
      end else if (w_exe_to_mem) begin
        r_exe.v <= 1'b0;
      end

      if (w_exe_to_mem)     r_mem   <= r_exe;
      else if (w_mem_to_wb) r_mem.v <= 1'b0;

      // WB retires every cycle, so it only stays valid when refilled.
      if (w_mem_to_wb) r_wb   <= r_mem;
      else             r_wb.v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (id_blocking && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, id_ren1, id_ren2, id_rf_we, id_is_load;
  logic [4:0] id_raddr1, id_raddr2, id_waddr;
  logic       exe_allowin, mem_allowin, wb_allowin;

  logic        blk, nf_blk;
  logic [1:0]  sel1, sel2, nf_sel1, nf_sel2;
  logic [31:0] cnt;
  logic [1:0]  nf_cnt;

  id_hazard_ctrl #(.FORWARD_EN(1), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .id_ren1(id_ren1), .id_ren2(id_ren2),
    .id_rf_we(id_rf_we), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .exe_allowin(exe_allowin), .mem_allowin(mem_allowin), .wb_allowin(wb_allowin),
    .id_blocking(blk), .fwd_sel1(sel1), .fwd_sel2(sel2), .stall_cnt(cnt)
  );

  // No-forwarding variant with a 2-bit counter so saturation is reachable.
  id_hazard_ctrl #(.FORWARD_EN(0), .CNT_W(2)) dut_nf (
    .clk(clk), .resetn(resetn), .id_valid(id_valid),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .id_ren1(id_ren1), .id_ren2(id_ren2),
    .id_rf_we(id_rf_we), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .exe_allowin(exe_allowin), .mem_allowin(mem_allowin), .wb_allowin(wb_allowin),
    .id_blocking(nf_blk), .fwd_sel1(nf_sel1), .fwd_sel2(nf_sel2), .stall_cnt(nf_cnt)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic       valid;
    logic [4:0] ra1;
    logic       ren1;
    logic [4:0] ra2;
    logic       ren2;
    logic       we;
    logic [4:0] wa;
    logic       ld;
    logic       ea;
    logic       ma;
    logic       wba;
    logic       e_blk;
    logic [1:0] e_s1;
    logic [1:0] e_s2;
    int         e_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int n_total = 0;
  int n_pass  = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    id_valid    = v.valid;
    id_raddr1   = v.ra1;
    id_ren1     = v.ren1;
    id_raddr2   = v.ra2;
    id_ren2     = v.ren2;
    id_rf_we    = v.we;
    id_waddr    = v.wa;
    id_is_load  = v.ld;
    exe_allowin = v.ea;
    mem_allowin = v.ma;
    wb_allowin  = v.wba;
  endtask

  task automatic do_reset();
    vec_t idle;
    idle = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0,
             1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 0};
    @(negedge clk);
    drive(idle);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic step(input logic valid, input logic [4:0] ra1, input logic ren1,
                      input logic [4:0] ra2, input logic ren2, input logic we,
                      input logic [4:0] wa, input logic ld, input logic ma);
    vec_t v;
    v = '{valid, ra1, ren1, ra2, ren2, we, wa, ld, 1'b1, ma, 1'b1,
          1'b0, 2'd0, 2'd0, 0};
    @(negedge clk);
    drive(v);
    #1;
  endtask

  initial begin
    //            val ra1 r1  ra2 r2  we  wa  ld  ea ma wb  blk s1 s2 cnt
    vecs[0]  = '{0,  0,  0,  0,  0,  0,  0,  0,  1, 1, 1,  0,  0, 0, 0}; // reset/idle
    vecs[1]  = '{1,  1,  1,  2,  1,  1,  5,  0,  1, 1, 1,  0,  0, 0, 0}; // add.w r5
    vecs[2]  = '{1,  5,  1,  0,  0,  0,  0,  0,  1, 1, 1,  0,  1, 0, 0}; // r5 in EXE
    vecs[3]  = '{1,  5,  1,  0,  0,  0,  0,  0,  1, 1, 1,  0,  2, 0, 0}; // r5 in MEM
    vecs[4]  = '{1,  0,  0,  5,  1,  0,  0,  0,  1, 1, 1,  0,  0, 3, 0}; // r5 in WB
    vecs[5]  = '{1,  5,  1,  0,  0,  1,  7,  1,  1, 1, 1,  0,  0, 0, 0}; // ld.w r7, r5 retired
    vecs[6]  = '{1,  3,  1,  7,  1,  0,  0,  0,  1, 1, 1,  1,  0, 1, 0}; // load-use
    vecs[7]  = '{1,  3,  1,  7,  1,  1,  9,  0,  1, 1, 1,  0,  0, 2, 1}; // load in MEM
    vecs[8]  = '{1,  0,  0,  0,  0,  1,  9,  0,  1, 1, 1,  0,  0, 0, 1}; // 2nd r9 writer
    vecs[9]  = '{1,  9,  1,  7,  1,  1,  0,  0,  1, 1, 1,  0,  1, 0, 1}; // r9 EXE+MEM, writes r0
    vecs[10] = '{1,  0,  1,  9,  1,  0,  0,  0,  1, 1, 1,  0,  0, 2, 1}; // r0 no hit, r9 MEM>WB
    vecs[11] = '{1,  0,  0,  0,  0,  1,  4,  1,  1, 1, 1,  0,  0, 0, 1}; // ld.w r4
    vecs[12] = '{1,  4,  1,  0,  0,  0,  0,  0,  1, 0, 1,  1,  1, 0, 1}; // stall, MEM busy
    vecs[13] = '{1,  4,  1,  0,  0,  0,  0,  0,  1, 1, 1,  1,  1, 0, 2}; // stall on held entry
    vecs[14] = '{1,  4,  1,  0,  0,  0,  0,  0,  0, 1, 1,  0,  2, 0, 3}; // EXE not accepting
    vecs[15] = '{1,  4,  1,  0,  0,  1,  6,  0,  1, 1, 1,  0,  3, 0, 3}; // r4 in WB, writes r6
    vecs[16] = '{0,  6,  1,  0,  0,  0,  0,  0,  1, 1, 1,  0,  0, 0, 3}; // invalid ID masks hit

    do_reset();

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d.blocking", i), {31'd0, blk},  {31'd0, vecs[i].e_blk});
      check($sformatf("v%0d.fwd_sel1", i), {30'd0, sel1}, {30'd0, vecs[i].e_s1});
      check($sformatf("v%0d.fwd_sel2", i), {30'd0, sel2}, {30'd0, vecs[i].e_s2});
      check($sformatf("v%0d.stall_cnt", i), cnt, vecs[i].e_cnt);
    end

    // ---- no-forwarding: stall through EXE, MEM, WB, then counter saturates ----
    do_reset();
    step(1, 5'd0, 0, 5'd0, 0, 1, 5'd3, 0, 1);
    check("nf.issue.blocking", {31'd0, nf_blk}, 0);
    for (int c = 0; c < 3; c++) begin
      step(1, 5'd3, 1, 5'd0, 0, 1, 5'd3, 0, 1);
      check($sformatf("nf.stall%0d.blocking", c), {31'd0, nf_blk}, 1);
      check($sformatf("nf.stall%0d.fwd_sel1", c), {30'd0, nf_sel1}, 0);
      check($sformatf("nf.stall%0d.cnt", c), {30'd0, nf_cnt}, c);
    end
    step(1, 5'd3, 1, 5'd0, 0, 1, 5'd3, 0, 1);
    check("nf.release.blocking", {31'd0, nf_blk}, 0);
    check("nf.release.fwd_sel1", {30'd0, nf_sel1}, 0);
    check("nf.release.cnt", {30'd0, nf_cnt}, 3);
    step(1, 5'd3, 1, 5'd0, 0, 1, 5'd3, 0, 1);
    check("nf.restall.blocking", {31'd0, nf_blk}, 1);
    step(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1);
    check("nf.saturate.cnt", {30'd0, nf_cnt}, 3);

    // ---- reset asserted during a load-use stall ----
    do_reset();
    step(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 1, 1);
    check("rst.ld.blocking", {31'd0, blk}, 0);
    step(1, 5'd0, 0, 5'd7, 1, 0, 5'd0, 0, 0);
    check("rst.stall0.blocking", {31'd0, blk}, 1);
    check("rst.stall0.cnt", cnt, 0);
    step(1, 5'd0, 0, 5'd7, 1, 0, 5'd0, 0, 0);
    check("rst.stall1.blocking", {31'd0, blk}, 1);
    check("rst.stall1.cnt", cnt, 1);
    #2 resetn = 1'b0;
    #1;
    check("rst.async.blocking", {31'd0, blk}, 0);
    check("rst.async.fwd_sel2", {30'd0, sel2}, 0);
    check("rst.async.cnt", cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    step(1, 5'd0, 0, 5'd7, 1, 0, 5'd0, 0, 1);
    check("rst.after.blocking", {31'd0, blk}, 0);
    check("rst.after.fwd_sel2", {30'd0, sel2}, 0);
    check("rst.after.nf_blocking", {31'd0, nf_blk}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
